// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register; at most one write commits per clock.
// Optional sticky ownership via lock input when SHARED_REG_LOCK_EN is defined.
module shared_reg_arbiter #(
    parameter int              N_REQ = 4,
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N_REQ-1:0]           lock,
`endif
    output logic [N_REQ-1:0]           ack,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [15:0]                wr_count
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        count_q, count_d;

    logic [N_REQ-1:0]   eligible;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   winner_next;
    logic               found;
    int                 scan_idx;

    // Eligibility: a requester acked last edge is masked so it cannot commit twice
    // on one stale req; a locked owner bypasses that mask and excludes everyone else.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
        eligible = req & ~ack_q;
        if (state_q == S_LOCKED) begin
            eligible          = '0;
            eligible[owner_q] = req[owner_q];
        end
    end

    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = PTR_W'(scan_idx);
            end
        end
    end

    assign winner_next = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);

    always_comb begin
        data_d   = data_q;
        ack_d    = '0;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (found) begin
            data_d        = wdata[int'(winner)*WIDTH +: WIDTH];
            ack_d[winner] = 1'b1;
            owner_d       = winner;
            count_d       = count_q + 16'd1;
            if (state_q == S_IDLE) rr_ptr_d = winner_next;
        end

`ifdef SHARED_REG_LOCK_EN
        case (state_q)
            S_IDLE:   if (found && lock[winner]) state_d = S_LOCKED;
            S_LOCKED: if (!lock[owner_q])        state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
`else
        state_d = S_IDLE;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            data_q   <= RESET;
            ack_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign q        = data_q;
    assign ack      = ack_q;
    assign owner    = owner_q;
    assign wr_count = count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=32, RESET=0).
// The lock scenario runs only when SHARED_REG_LOCK_EN is defined.
module tb_shared_reg_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*WIDTH-1:0]   wdata = '0;
    logic [N_REQ-1:0]         ack;
    logic [WIDTH-1:0]         q;
    logic [1:0]               owner;
    logic [15:0]              wr_count;
`ifdef SHARED_REG_LOCK_EN
    logic [N_REQ-1:0]         lock = '0;
`endif

    int checks   = 0;
    int failures = 0;

    shared_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .RESET(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock     (lock),
`endif
        .ack      (ack),
        .q        (q),
        .owner    (owner),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_wdata(input logic [WIDTH-1:0] base);
        for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (q !== 32'h0)      begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
        checks++; if (ack !== 4'b0000)  begin failures++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        checks++; if (owner !== 2'd0)   begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end

        set_wdata(32'h7700_0000);
        req = 4'b1111;
        tick();
        tick();
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL pre_midreset_ack got=%b exp=%b", ack, 4'b0010); end
        checks++; if (wr_count !== 16'd2) begin failures++; $display("FAIL pre_midreset_count got=%0d exp=2", wr_count); end

        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 32'h0)      begin failures++; $display("FAIL async_reset_q got=%h exp=%h", q, 32'h0); end
        checks++; if (ack !== 4'b0000)  begin failures++; $display("FAIL async_reset_ack got=%b exp=%b", ack, 4'b0000); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", wr_count); end

        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rearb_ack got=%b exp=%b", ack, 4'b0001); end
        checks++; if (q !== 32'h7700_0000) begin failures++; $display("FAIL rearb_q got=%h exp=%h", q, 32'h7700_0000); end
        req = '0;
    endtask

    task automatic test_single_writer();
        do_reset();
        wdata = '0;
        wdata[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        checks++; if (q !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_q got=%h exp=%h", q, 32'hDEAD_BEEF); end
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=%b", ack, 4'b0100); end
        checks++; if (owner !== 2'd2)  begin failures++; $display("FAIL single_owner got=%0d exp=2", owner); end
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_count); end
        tick();
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL single_ack_drop got=%b exp=%b", ack, 4'b0000); end
        checks++; if (q !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_q_hold got=%h exp=%h", q, 32'hDEAD_BEEF); end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_ack;
        logic [31:0] exp_q;
        do_reset();
        set_wdata(32'hA000_0000);
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            tick();
            exp_ack = 4'b0001 << (n % 4);
            exp_q   = 32'hA000_0000 + 32'(n % 4);
            checks++; if (ack !== exp_ack) begin failures++; $display("FAIL fair_ack[%0d] got=%b exp=%b", n, ack, exp_ack); end
            checks++; if (q !== exp_q)     begin failures++; $display("FAIL fair_q[%0d] got=%h exp=%h", n, q, exp_q); end
        end
        req = 4'b0000;
        checks++; if (wr_count !== 16'd8) begin failures++; $display("FAIL fair_count got=%0d exp=8", wr_count); end
    endtask

    task automatic test_rotation();
        do_reset();
        set_wdata(32'hB000_0000);
        req = 4'b0001;
        tick();
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rot_first_ack got=%b exp=%b", ack, 4'b0001); end
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL rot_ack3 got=%b exp=%b", ack, 4'b1000); end
        checks++; if (owner !== 2'd3)  begin failures++; $display("FAIL rot_owner3 got=%0d exp=3", owner); end
        req = 4'b0001;
        tick();
        req = 4'b0000;
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rot_ack0 got=%b exp=%b", ack, 4'b0001); end
        checks++; if (q !== 32'hB000_0000) begin failures++; $display("FAIL rot_q0 got=%h exp=%h", q, 32'hB000_0000); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_wdata(32'h5000_0000);
        req = 4'b1111;
        repeat (65535) tick();
        checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", wr_count, 16'hFFFF); end
        set_wdata(32'hC000_0000);
        tick();
        req = 4'b0000;
        checks++; if (wr_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=%h", wr_count, 16'h0000); end
        checks++; if (q !== 32'hC000_0003) begin failures++; $display("FAIL wrap_q got=%h exp=%h", q, 32'hC000_0003); end
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL wrap_ack got=%b exp=%b", ack, 4'b1000); end
    endtask

`ifdef SHARED_REG_LOCK_EN
    task automatic test_lock();
        logic [31:0] exp_q;
        do_reset();
        set_wdata(32'hE000_0000);
        wdata[1*WIDTH +: WIDTH] = 32'h1111_0000;
        req  = 4'b0010;
        lock = 4'b0010;
        tick();
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL lock_win_ack got=%b exp=%b", ack, 4'b0010); end
        checks++; if (owner !== 2'd1)  begin failures++; $display("FAIL lock_win_owner got=%0d exp=1", owner); end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_q = 32'h1111_0001 + 32'(n);
            wdata[1*WIDTH +: WIDTH] = exp_q;
            tick();
            checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL lock_hold_ack[%0d] got=%b exp=%b", n, ack, 4'b0010); end
            checks++; if (q !== exp_q)     begin failures++; $display("FAIL lock_hold_q[%0d] got=%h exp=%h", n, q, exp_q); end
        end
        lock = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL lock_exit_ack got=%b exp=%b", ack, 4'b0010); end
        tick();
        req = 4'b0000;
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL lock_next_ack got=%b exp=%b", ack, 4'b0100); end
        checks++; if (owner !== 2'd2)  begin failures++; $display("FAIL lock_next_owner got=%0d exp=2", owner); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_writer();
        test_fairness();
        test_rotation();
        test_wrap();
`ifdef SHARED_REG_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
